// File: rtl/vga_line_prefetcher.sv
// Ping-pong line buffer in front of the VGA output stage: serves pixel reads from
// two cached scan lines and prefetches the next visible line one memory word at a time.
module vga_line_prefetcher #(
    parameter int          BITS_PER_PIXEL = 4,
    parameter int          LINE_PIXELS    = 640,
    parameter int          VISIBLE_LINES  = 480,
    parameter int          MEM_DATA_WIDTH = 32,
    parameter logic [31:0] FB_BASE_ADDR   = 32'h0
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic [31:0]               i_Fb_Read_Addr,
    output logic [BITS_PER_PIXEL-1:0] o_Fb_Read_Data,
    output logic                      o_Mem_Req,
    output logic [31:0]               o_Mem_Addr,
    input  logic                      i_Mem_Ack,
    input  logic                      i_Mem_Valid,
    input  logic [MEM_DATA_WIDTH-1:0] i_Mem_Data,
    output logic                      o_Underrun
);
    localparam int PPW = MEM_DATA_WIDTH / BITS_PER_PIXEL;
    localparam int WPL = LINE_PIXELS / PPW;
    localparam int LW  = (VISIBLE_LINES > 1) ? $clog2(VISIBLE_LINES) : 1;
    localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [31:0]   LP32      = 32'(LINE_PIXELS);
    localparam logic [31:0]   VIS_END   = 32'(LINE_PIXELS * VISIBLE_LINES);
    localparam logic [WW-1:0] LAST_WORD = WW'(WPL - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(VISIBLE_LINES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;

    function automatic logic [31:0] byte_addr(input logic [31:0] pix);
        byte_addr = FB_BASE_ADDR + ((pix * 32'(BITS_PER_PIXEL)) >> 3);
    endfunction

    state_t                    state_q, state_d;
    logic [WW-1:0]             word_q, word_d;
    logic                      dest_q, dest_d;
    logic                      last_hit_q, last_hit_d;
    logic [1:0]                valid_q, valid_d;
    logic [LW-1:0]             line_q [2];
    logic [LW-1:0]             line_d [2];
    logic [31:0]               base_q [2];
    logic [31:0]               base_d [2];
    logic                      mem_req_q, mem_req_d;
    logic [31:0]               mem_addr_q, mem_addr_d;
    logic [BITS_PER_PIXEL-1:0] rd_data_q, rd_data_d;
    logic                      underrun_q, underrun_d;
    logic                      wr_en;

    logic [MEM_DATA_WIDTH-1:0] line_mem [2][WPL];

    logic [31:0]               off0, off1, off, rd_slot;
    logic                      hit0, hit1, hit_any, hit_sel;
    logic [WW-1:0]             rd_word, word_nxt;
    logic [MEM_DATA_WIDTH-1:0] sel_word, shifted;
    logic [LW-1:0]             nxt_line, tgt;
    logic                      dst, held;
    logic [31:0]               tgt_base;

    // Hit detection and pixel extraction; unsigned wrap makes addr < base a miss.
    always_comb begin
        off0       = i_Fb_Read_Addr - base_q[0];
        off1       = i_Fb_Read_Addr - base_q[1];
        hit0       = valid_q[0] && (off0 < LP32);
        hit1       = valid_q[1] && (off1 < LP32);
        hit_any    = hit0 | hit1;
        hit_sel    = hit1;
        off        = hit1 ? off1 : off0;
        rd_word    = WW'(off / 32'(PPW));
        rd_slot    = off % 32'(PPW);
        sel_word   = line_mem[hit_sel][rd_word];
        shifted    = sel_word >> (rd_slot * 32'(BITS_PER_PIXEL));
        rd_data_d  = hit_any ? shifted[BITS_PER_PIXEL-1:0] : '0;
        underrun_d = !hit_any && (i_Fb_Read_Addr < VIS_END);
    end

    // Prefetch target: the line after the one being displayed, or line 0 when nothing hits.
    always_comb begin
        nxt_line = (line_q[hit_sel] == LAST_LINE) ? '0 : line_q[hit_sel] + 1'b1;
        tgt      = hit_any ? nxt_line : '0;
        dst      = hit_any ? ~hit_sel : ~last_hit_q;
        tgt_base = 32'(tgt) * LP32;
        held     = (valid_q[0] && (line_q[0] == tgt)) || (valid_q[1] && (line_q[1] == tgt));
        word_nxt = word_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        dest_d     = dest_q;
        last_hit_d = last_hit_q;
        valid_d    = valid_q;
        line_d     = line_q;
        base_d     = base_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_any) begin
                    last_hit_d = hit_sel;
                end
                if (!held) begin
                    valid_d[dst] = 1'b0;
                    line_d[dst]  = tgt;
                    base_d[dst]  = tgt_base;
                    word_d       = '0;
                    dest_d       = dst;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = byte_addr(tgt_base);
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (i_Mem_Ack) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (i_Mem_Valid) begin
                    wr_en = 1'b1;
                    if (word_q == LAST_WORD) begin
                        valid_d[dest_q] = 1'b1;
                        state_d         = IDLE;
                    end else begin
                        word_d     = word_nxt;
                        mem_req_d  = 1'b1;
                        mem_addr_d = byte_addr(base_q[dest_q] + 32'(word_nxt) * 32'(PPW));
                        state_d    = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            dest_q     <= 1'b0;
            last_hit_q <= 1'b1;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rd_data_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            dest_q     <= dest_d;
            last_hit_q <= last_hit_d;
            valid_q    <= valid_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_data_q  <= rd_data_d;
            underrun_q <= underrun_d;
        end
    end

    // Line tags and buffer contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge i_Clock) begin
        line_q <= line_d;
        base_q <= base_d;
        if (wr_en) begin
            line_mem[dest_q][word_q] <= i_Mem_Data;
        end
    end

    assign o_Fb_Read_Data = rd_data_q;
    assign o_Mem_Req      = mem_req_q;
    assign o_Mem_Addr     = mem_addr_q;
    assign o_Underrun     = underrun_q;
endmodule
